// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: serializes CPU and host accesses onto one synchronous-read RAM port,
// bounds consecutive host grants while the CPU waits, and lets the host freeze CPU traffic.
module mem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int MAX_STREAK = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_ack,
  output logic [DATA_W-1:0] o_host_rdata,
  input  logic              i_host_hold,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_busy
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner_host;
  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_next_streak;
  logic                w_grant_cpu;
  logic                w_grant_host;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic                r_ram_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_cpu || w_grant_host) w_next_state = ISSUE;
      ISSUE:   w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Hold overrides everything; otherwise the CPU wins a tie only once the host streak is exhausted.
  always_comb begin
    w_grant_cpu  = 1'b0;
    w_grant_host = 1'b0;
    if (r_state == IDLE) begin
      if (i_host_hold)                                        w_grant_host = i_host_req;
      else if (i_cpu_req && i_host_req && r_streak == STREAK_LIMIT) w_grant_cpu = 1'b1;
      else if (i_host_req)                                    w_grant_host = 1'b1;
      else if (i_cpu_req)                                     w_grant_cpu  = 1'b1;
    end
  end

  always_comb begin
    w_next_streak = r_streak;
    if (!i_host_hold) begin
      if (w_grant_cpu) begin
        w_next_streak = '0;
      end else if (w_grant_host) begin
        if (!i_cpu_req)                  w_next_streak = '0;
        else if (r_streak != STREAK_LIMIT) w_next_streak = r_streak + STREAK_W'(1);
      end
    end
  end

  // The RAM command is latched at grant time; ram_we only survives the single ISSUE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner_host <= 1'b0;
      r_streak     <= '0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_ram_we     <= 1'b0;
    end else begin
      r_streak <= w_next_streak;
      if (w_grant_cpu) begin
        r_owner_host <= 1'b0;
        r_ram_addr   <= i_cpu_addr;
        r_ram_wdata  <= i_cpu_wdata;
        r_ram_we     <= i_cpu_we;
      end else if (w_grant_host) begin
        r_owner_host <= 1'b1;
        r_ram_addr   <= i_host_addr;
        r_ram_wdata  <= i_host_wdata;
        r_ram_we     <= i_host_we;
      end else begin
        r_ram_we <= 1'b0;
      end
    end
  end

  always_comb begin
    o_cpu_ack    = (r_state == RESP) && !r_owner_host;
    o_host_ack   = (r_state == RESP) &&  r_owner_host;
    o_busy       = (r_state != IDLE);
    o_cpu_rdata  = i_ram_rdata;
    o_host_rdata = i_ram_rdata;
    o_ram_addr   = r_ram_addr;
    o_ram_wdata  = r_ram_wdata;
    o_ram_we     = r_ram_we;
  end

endmodule
